// File: rtl/attr_stream_parser.sv
// Character-stream parser for HTML-style attributes (name=value), producing a
// type code plus a saturating decimal or hex value through a valid/ready result port.
module attr_stream_parser #(
    parameter int VAL_WIDTH  = 24,
    parameter int TYPE_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            in_char,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TYPE_WIDTH-1:0] out_type,
    output logic [VAL_WIDTH-1:0]  out_value,
    output logic                  out_overflow,
    output logic                  out_error
);

    typedef enum logic [2:0] {IDLE, NAME, SKIP, VAL_START, DEC, HEX, RESULT} state_t;

    localparam int                   HEX_DIGITS = VAL_WIDTH / 4;
    localparam logic [VAL_WIDTH-1:0] VAL_MAX    = '1;

    state_t               state_q, state_d;
    logic [7:0]           name0_q, name0_d, name1_q, name1_d, quote_q, quote_d;
    logic [VAL_WIDTH-1:0] value_q, value_d;
    logic                 ovf_q, ovf_d, err_q, err_d;
    logic [3:0]           hcnt_q, hcnt_d;

    logic                  accept, isDigit, isHex, isQuote, isTerm, decOver;
    logic [3:0]            hexNibble;
    logic [VAL_WIDTH+3:0]  decSum;
    logic [TYPE_WIDTH-1:0] typeCode;

    assign accept    = in_valid && in_ready;
    assign isDigit   = (in_char >= "0") && (in_char <= "9");
    assign isHex     = isDigit || ((in_char >= "a") && (in_char <= "f"))
                               || ((in_char >= "A") && (in_char <= "F"));
    assign hexNibble = isDigit ? in_char[3:0] : (in_char[3:0] + 4'd9);
    assign isQuote   = (in_char == 8'h22) || (in_char == 8'h27);
    // An open quote makes only its matching quote a terminator; space and '>' become errors.
    assign isTerm    = (quote_q == 8'h00) ? ((in_char == " ") || (in_char == ">"))
                                          : (in_char == quote_q);
    assign decSum    = ({4'b0000, value_q} * (VAL_WIDTH+4)'(10))
                     + {{VAL_WIDTH{1'b0}}, in_char[3:0]};
    assign decOver   = |decSum[VAL_WIDTH+3:VAL_WIDTH];

    always_comb begin
        typeCode = '0;
        case ({name0_q, name1_q})
            "co":    typeCode = TYPE_WIDTH'(1);
            "si":    typeCode = TYPE_WIDTH'(2);
            "wi":    typeCode = TYPE_WIDTH'(3);
            "he":    typeCode = TYPE_WIDTH'(4);
            "sr":    typeCode = TYPE_WIDTH'(5);
            "hr":    typeCode = TYPE_WIDTH'(6);
            "ba":    typeCode = TYPE_WIDTH'(7);
            "pa":    typeCode = TYPE_WIDTH'(8);
            "ma":    typeCode = TYPE_WIDTH'(9);
            "bo":    typeCode = TYPE_WIDTH'(10);
            "po":    typeCode = TYPE_WIDTH'(11);
            default: typeCode = '0;
        endcase
    end

    assign in_ready     = (state_q != RESULT);
    assign out_valid    = (state_q == RESULT);
    assign out_type     = out_valid ? typeCode : '0;
    assign out_value    = out_valid ? value_q : '0;
    assign out_overflow = out_valid && ovf_q;
    assign out_error    = out_valid && err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            name0_q <= '0;
            name1_q <= '0;
            quote_q <= '0;
            value_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            name0_q <= name0_d;
            name1_q <= name1_d;
            quote_q <= quote_d;
            value_q <= value_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        name0_d = name0_q;
        name1_d = name1_q;
        quote_d = quote_q;
        value_d = value_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            IDLE: if (accept && !isTerm) begin
                name0_d = in_char;
                state_d = NAME;
            end
            NAME: if (accept) begin
                if (in_char == "=") begin
                    state_d = VAL_START;
                end else if (isTerm) begin
                    name0_d = '0;
                    state_d = IDLE;
                end else begin
                    name1_d = in_char;
                    state_d = SKIP;
                end
            end
            SKIP: if (accept) begin
                if (in_char == "=") begin
                    state_d = VAL_START;
                end else if (isTerm) begin
                    name0_d = '0;
                    name1_d = '0;
                    state_d = IDLE;
                end
            end
            VAL_START: if (accept) begin
                if (isTerm) begin
                    state_d = RESULT;
                end else if (isQuote && (quote_q == 8'h00)) begin
                    quote_d = in_char;
                end else if (in_char == "#") begin
                    state_d = HEX;
                end else if (isDigit) begin
                    value_d = VAL_WIDTH'(in_char[3:0]);
                    state_d = DEC;
                end else begin
                    err_d   = 1'b1;
                    state_d = DEC;
                end
            end
            DEC: if (accept) begin
                if (isTerm) begin
                    state_d = RESULT;
                end else if (isDigit) begin
                    value_d = decOver ? VAL_MAX : decSum[VAL_WIDTH-1:0];
                    ovf_d   = ovf_q || decOver;
                end else begin
                    err_d = 1'b1;
                end
            end
            HEX: if (accept) begin
                if (isTerm) begin
                    state_d = RESULT;
                end else if (isHex) begin
                    if (hcnt_q == 4'(HEX_DIGITS)) begin
                        value_d = VAL_MAX;
                        ovf_d   = 1'b1;
                    end else begin
                        value_d = {value_q[VAL_WIDTH-5:0], hexNibble};
                        hcnt_d  = hcnt_q + 4'd1;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            RESULT: if (out_ready) begin
                name0_d = '0;
                name1_d = '0;
                quote_d = '0;
                value_d = '0;
                ovf_d   = 1'b0;
                err_d   = 1'b0;
                hcnt_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_attr_stream_parser.sv
// Directed bench for attr_stream_parser: a 24-bit instance for most vectors and an
// 8-bit instance for narrow saturation, plus hand sequences for backpressure and reset.
module tb_attr_stream_parser;

    typedef struct packed {
        logic         sel8;
        logic [191:0] text;
        logic [1:0]   nRes;
        logic [3:0]   eType;
        logic [31:0]  eValue;
        logic         eOvf;
        logic         eErr;
    } vecT;

    typedef struct packed {
        logic [3:0]  t;
        logic [31:0] v;
        logic        o;
        logic        e;
    } resT;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [7:0]  inChar = 8'h00, inChar8 = 8'h00;
    logic        inValid = 1'b0, inValid8 = 1'b0;
    logic        outReady = 1'b1, outReady8 = 1'b1;
    logic        inReady, inReady8, outValid, outValid8;
    logic [3:0]  outType, outType8;
    logic [23:0] outValue;
    logic [7:0]  outValue8;
    logic        outOvf, outOvf8, outErr, outErr8;

    int  checks = 0;
    int  errors = 0;
    resT q24[$];
    resT q8[$];
    vecT vecs[$];

    always #5 clock = ~clock;

    attr_stream_parser #(.VAL_WIDTH(24), .TYPE_WIDTH(4)) dut (
        .clock(clock), .reset_n(resetN), .in_char(inChar), .in_valid(inValid),
        .in_ready(inReady), .out_valid(outValid), .out_ready(outReady),
        .out_type(outType), .out_value(outValue), .out_overflow(outOvf), .out_error(outErr)
    );

    attr_stream_parser #(.VAL_WIDTH(8), .TYPE_WIDTH(4)) dut8 (
        .clock(clock), .reset_n(resetN), .in_char(inChar8), .in_valid(inValid8),
        .in_ready(inReady8), .out_valid(outValid8), .out_ready(outReady8),
        .out_type(outType8), .out_value(outValue8), .out_overflow(outOvf8), .out_error(outErr8)
    );

    // Results are captured the half cycle before the edge that transfers them.
    always @(negedge clock) begin
        if (outValid && outReady) q24.push_back({outType, {8'h00, outValue}, outOvf, outErr});
        if (outValid8 && outReady8) q8.push_back({outType8, {24'h0, outValue8}, outOvf8, outErr8});
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic readyOf(input logic sel);
        return sel ? inReady8 : inReady;
    endfunction

    task automatic sendChar(input logic sel, input logic [7:0] ch);
        int guard = 0;
        @(negedge clock);
        if (sel) begin inChar8 = ch; inValid8 = 1'b1; end
        else     begin inChar  = ch; inValid  = 1'b1; end
        while (!readyOf(sel) && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clock);
    endtask

    // Streams the non-zero bytes of a right-justified text, then idles the input at the next negedge.
    task automatic applyStimulus(input logic sel, input logic [191:0] text);
        for (int i = 23; i >= 0; i--) begin
            if (text[i*8 +: 8] != 8'h00) sendChar(sel, text[i*8 +: 8]);
        end
        @(negedge clock);
        inValid  = 1'b0;
        inValid8 = 1'b0;
    endtask

    task automatic addVec(input logic sel, input logic [191:0] text, input logic [1:0] n,
                          input logic [3:0] t, input logic [31:0] v, input logic o, input logic e);
        vecs.push_back({sel, text, n, t, v, o, e});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resT r;
        addVec(0, "color=\"#ff8000\"",  1, 1,  32'hFF8000, 0, 0);
        addVec(0, "color=#1234567>",    1, 1,  32'hFFFFFF, 1, 0);
        addVec(0, "height=7>",          1, 4,  32'd7,      0, 0);
        addVec(0, "src='abc' ",         1, 5,  32'd0,      0, 1);
        addVec(0, "x=5>",               1, 0,  32'd5,      0, 0);
        addVec(0, "background=#0aB>",   1, 7,  32'h0AB,    0, 0);
        addVec(0, "border=\"\"",        1, 10, 32'd0,      0, 0);
        addVec(0, "position=12\"3>",    1, 11, 32'd123,    0, 1);
        addVec(0, "  margin=42 ",       1, 9,  32'd42,     0, 0);
        addVec(0, "abc> ",              0, 0,  32'd0,      0, 0);
        addVec(0, "hr=#FFFFFF>",        1, 6,  32'hFFFFFF, 0, 0);
        addVec(0, "size=16777215>",     1, 2,  32'hFFFFFF, 0, 0);
        addVec(0, "size=16777216>",     1, 2,  32'hFFFFFF, 1, 0);
        addVec(1, "size=300>",          1, 2,  32'd255,    1, 0);
        addVec(1, "size=3x>",           1, 2,  32'd3,      0, 1);
        addVec(1, "size=255>",          1, 2,  32'd255,    0, 0);
        addVec(1, "si=#FF>",            1, 2,  32'hFF,     0, 0);
        addVec(1, "si=#100>",           1, 2,  32'hFF,     1, 0);

        repeat (3) @(negedge clock);
        checkOutput("reset_out_valid", {31'b0, outValid}, 0);
        checkOutput("reset_out_type", {28'b0, outType}, 0);
        checkOutput("reset_out_value", {8'b0, outValue}, 0);
        checkOutput("reset_out_overflow", {31'b0, outOvf}, 0);
        checkOutput("reset_out_error", {31'b0, outErr}, 0);
        resetN = 1'b1;
        @(negedge clock);
        checkOutput("reset_in_ready", {31'b0, inReady}, 1);

        // Latency: result visible the cycle right after the terminating space, gone the next.
        q24.delete();
        applyStimulus(0, "width=120 ");
        checkOutput("lat_out_valid", {31'b0, outValid}, 1);
        checkOutput("lat_out_type", {28'b0, outType}, 3);
        checkOutput("lat_out_value", {8'b0, outValue}, 120);
        checkOutput("lat_out_flags", {30'b0, outOvf, outErr}, 0);
        @(negedge clock);
        checkOutput("lat_out_valid_drop", {31'b0, outValid}, 0);
        checkOutput("lat_result_count", q24.size(), 1);

        foreach (vecs[k]) begin
            q24.delete();
            q8.delete();
            applyStimulus(vecs[k].sel8, vecs[k].text);
            repeat (3) @(negedge clock);
            checkOutput($sformatf("vec%0d_count", k), vecs[k].sel8 ? q8.size() : q24.size(), 32'(vecs[k].nRes));
            if (vecs[k].nRes == 2'd1 && (vecs[k].sel8 ? q8.size() : q24.size()) > 0) begin
                r = vecs[k].sel8 ? q8[0] : q24[0];
                checkOutput($sformatf("vec%0d_type", k), {28'b0, r.t}, {28'b0, vecs[k].eType});
                checkOutput($sformatf("vec%0d_value", k), r.v, vecs[k].eValue);
                checkOutput($sformatf("vec%0d_overflow", k), {31'b0, r.o}, {31'b0, vecs[k].eOvf});
                checkOutput($sformatf("vec%0d_error", k), {31'b0, r.e}, {31'b0, vecs[k].eErr});
            end
        end

        // Backpressure: held result blocks input until the consumer takes it.
        q24.delete();
        outReady = 1'b0;
        applyStimulus(0, "sr=9>");
        fork
            applyStimulus(0, "height=7>");
            begin
                for (int i = 0; i < 5; i++) begin
                    checkOutput($sformatf("bp%0d_out_valid", i), {31'b0, outValid}, 1);
                    checkOutput($sformatf("bp%0d_in_ready", i), {31'b0, inReady}, 0);
                    checkOutput($sformatf("bp%0d_out_type", i), {28'b0, outType}, 5);
                    checkOutput($sformatf("bp%0d_out_value", i), {8'b0, outValue}, 9);
                    @(negedge clock);
                end
                @(posedge clock);
                #1 outReady = 1'b1;
            end
        join
        repeat (3) @(negedge clock);
        checkOutput("bp_result_count", q24.size(), 2);
        if (q24.size() == 2) begin
            checkOutput("bp_first_value", q24[0].v, 9);
            checkOutput("bp_second_type", {28'b0, q24[1].t}, 4);
            checkOutput("bp_second_value", q24[1].v, 7);
        end

        // Asynchronous reset while a result is pending clears outputs without a clock edge.
        outReady = 1'b0;
        applyStimulus(0, "co=5>");
        checkOutput("ar_pending_valid", {31'b0, outValid}, 1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("ar_out_valid", {31'b0, outValid}, 0);
        checkOutput("ar_out_type", {28'b0, outType}, 0);
        checkOutput("ar_out_value", {8'b0, outValue}, 0);
        @(negedge clock);
        resetN = 1'b1;
        outReady = 1'b1;

        // Reset mid-value: stale margin state must not leak into the next attribute.
        applyStimulus(0, "margin=4");
        #1 resetN = 1'b0;
        #1;
        checkOutput("mr_out_valid", {31'b0, outValid}, 0);
        checkOutput("mr_out_value", {8'b0, outValue}, 0);
        checkOutput("mr_in_ready", {31'b0, inReady}, 1);
        @(negedge clock);
        resetN = 1'b1;
        q24.delete();
        applyStimulus(0, "padding=9 ");
        repeat (2) @(negedge clock);
        checkOutput("mr_result_count", q24.size(), 1);
        if (q24.size() > 0) begin
            checkOutput("mr_type", {28'b0, q24[0].t}, 8);
            checkOutput("mr_value", q24[0].v, 9);
            checkOutput("mr_flags", {30'b0, q24[0].o, q24[0].e}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/attr_stream_parser.md
ATTR_STREAM_PARSER -- requirements
Module: attr_stream_parser

Interface
REQ-001 Parameter VAL_WIDTH, default 24: width of parsed attribute value; legal 8..32, multiple of 4.
REQ-002 Parameter TYPE_WIDTH, default 4: width of attribute type code.
REQ-003 clock  in  1  sole clock; all state changes on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_char  in  8  ASCII character of attribute text.
REQ-006 in_valid  in  1  in_char valid this cycle.
REQ-007 in_ready  out  1  parser accepts in_char; a character is consumed when in_valid&&in_ready.
REQ-008 out_valid  out  1  parsed attribute result held on out_* ports.
REQ-009 out_ready  in  1  consumer accepts result; a result transfers when out_valid&&out_ready.
REQ-010 out_type  out  TYPE_WIDTH  attribute type code.
REQ-011 out_value  out  VAL_WIDTH  parsed numeric value.
REQ-012 out_overflow  out  1  value saturated.
REQ-013 out_error  out  1  malformed value.

Function
REQ-014 States SHALL be IDLE, NAME, SKIP, VAL_START, DEC, HEX, RESULT.
REQ-015 in_ready SHALL be 1 in every state except RESULT.
REQ-016 IDLE: space chars ignored; any other char -> NAME, char stored as name[0].
REQ-017 NAME: second consumed char stored as name[1], then -> SKIP; '=' consumed in NAME or SKIP -> VAL_START.
REQ-018 SKIP: all chars other than '=' ignored.
REQ-019 Type SHALL be fixed from name[0..1]: co=1 color, si=2 size, wi=3 width, he=4 height, sr=5 src, hr=6 href, ba=7 bg, pa=8 padding, ma=9 margin, bo=10 border, po=11 position, all others=0.
REQ-020 A one-char name followed by '=' SHALL produce type 0.
REQ-021 VAL_START: '"' or ''' recorded as open quote (at most one), stays; '#' -> HEX; digit '0'-'9' -> DEC with value=digit; terminator -> RESULT with value 0; else sets error, -> DEC.
REQ-022 Terminator SHALL be space or '>' when unquoted, the matching quote char when quoted.
REQ-023 DEC: value <= value*10+digit, computed VAL_WIDTH+4 bits wide; result above 2^VAL_WIDTH-1 saturates to all-ones and sets overflow (sticky).
REQ-024 HEX: '0'-'9','a'-'f','A'-'F' shift value left 4 and OR nibble; a digit arriving after VAL_WIDTH/4 digits saturates to all-ones and sets overflow.
REQ-025 In DEC/HEX a non-digit non-terminator SHALL set error (sticky) and leave value unchanged.
REQ-026 Consumed terminator SHALL move to RESULT in the same edge; out_valid=1 the next cycle (1-cycle latency from terminator).
REQ-027 RESULT: out_* held stable while out_valid&&!out_ready.
REQ-028 Transfer in RESULT -> IDLE, internal value/flags/name cleared; out_valid=0 next cycle.
REQ-029 A terminator with no '=' seen (IDLE/NAME/SKIP) SHALL discard the partial name and return to IDLE, emitting no result.
REQ-030 Unquoted quote char in DEC/HEX SHALL be an error, not a terminator.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, out_valid=0, out_type=0, out_value=0, out_overflow=0, out_error=0, name/quote/value registers 0, regardless of state or pending handshake.
REQ-032 First char with in_valid after reset_n rises SHALL be accepted on the next clock edge.

Verification
REQ-033 "width=120 " streamed, out_ready=1 -> one result: type 3, value 120, overflow 0, error 0, out_valid 1 cycle after space.
REQ-034 "color=\"#ff8000\"" -> type 1, value 0xFF8000; "color=#1234567>" -> value 0xFFFFFF, overflow 1.
REQ-035 VAL_WIDTH=8, "size=300>" -> value 255, overflow 1; "size=3x>" -> value 3, error 1.
REQ-036 Result with out_ready=0 for 5 cycles -> in_ready 0, out_* stable, next attribute "height=7>" parsed only after transfer (type 4, value 7).
REQ-037 Assert reset_n low mid-value during "margin=45" after '4' -> outputs 0 asynchronously; "padding=9 " afterwards -> type 8, value 9.
